// File: rtl/starsoc_params.sv
// Shared video timing parameters: per-mode timing fields, the mode table and the
// legacy 640x480 constants that older blocks still reference.
package starsoc_params;

  typedef struct packed {
    logic [11:0] h_vis;
    logic [11:0] hfp;
    logic [11:0] hsw;
    logic [11:0] hbp;
    logic [11:0] v_vis;
    logic [11:0] vfp;
    logic [11:0] vsw;
    logic [11:0] vbp;
    logic        pol;
  } timing_t;

  // Entry [n] is the timing of mode n.
  typedef timing_t [2:0] mode_table_t;

  localparam int h_visible = 640;
  localparam int v_visible = 480;
  localparam int h_max     = 800;
  localparam int v_max     = 525;

  localparam timing_t MODE_640X480 = '{h_vis: 12'd640, hfp: 12'd16, hsw: 12'd96, hbp: 12'd48,
                                       v_vis: 12'd480, vfp: 12'd10, vsw: 12'd2, vbp: 12'd33,
                                       pol: 1'b1};
  localparam timing_t MODE_800X600 = '{h_vis: 12'd800, hfp: 12'd40, hsw: 12'd128, hbp: 12'd88,
                                       v_vis: 12'd600, vfp: 12'd1, vsw: 12'd4, vbp: 12'd23,
                                       pol: 1'b1};
  localparam timing_t MODE_1280X720 = '{h_vis: 12'd1280, hfp: 12'd110, hsw: 12'd40, hbp: 12'd220,
                                        v_vis: 12'd720, vfp: 12'd5, vsw: 12'd5, vbp: 12'd20,
                                        pol: 1'b1};

  localparam mode_table_t MODE_TABLE = {MODE_1280X720, MODE_800X600, MODE_640X480};

  function automatic logic [15:0] line_total(input timing_t t);
    return 16'(t.h_vis) + 16'(t.hfp) + 16'(t.hsw) + 16'(t.hbp);
  endfunction

  function automatic logic [15:0] frame_total(input timing_t t);
    return 16'(t.v_vis) + 16'(t.vfp) + 16'(t.vsw) + 16'(t.vbp);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Control inputs and timing outputs of the video timing generator.
interface video_timing_gen_if #(
  parameter int COORD_W = 12,
  parameter int FCNT_W  = 16
);
  logic               vtg_ce;
  logic [1:0]         mode_sel;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               hsync;
  logic               vsync;
  logic               hblank;
  logic               vblank;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic [FCNT_W-1:0]  frame_count;
  logic [1:0]         mode_active;
  logic               mode_err;

  modport master (
    input  vtg_ce, mode_sel,
    output pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on,
           line_start, frame_start, frame_count, mode_active, mode_err
  );

  modport slave (
    output vtg_ce, mode_sel,
    input  pixel_x, pixel_y, hsync, vsync, hblank, vblank, video_on,
           line_start, frame_start, frame_count, mode_active, mode_err
  );
endinterface

// File: rtl/vtg_mode_decode.sv
// Combinational lookup of the counter limits and sync/blank boundaries for a mode.
module vtg_mode_decode
  import starsoc_params::*;
#(
  parameter int          COORD_W = 12,
  parameter mode_table_t TIMING  = MODE_TABLE
) (
  input  logic [1:0]         mode,
  output logic [COORD_W-1:0] h_last,
  output logic [COORD_W-1:0] v_last,
  output logic [COORD_W-1:0] h_vis,
  output logic [COORD_W-1:0] v_vis,
  output logic [COORD_W-1:0] hs_first,
  output logic [COORD_W-1:0] hs_last,
  output logic [COORD_W-1:0] vs_first,
  output logic [COORD_W-1:0] vs_last,
  output logic               pol
);
  timing_t t;

  // Mode 3 never becomes active; it falls back to entry 0 so the decode is total.
  always_comb begin
    case (mode)
      2'd1:    t = TIMING[1];
      2'd2:    t = TIMING[2];
      default: t = TIMING[0];
    endcase
    h_vis    = COORD_W'(t.h_vis);
    v_vis    = COORD_W'(t.v_vis);
    h_last   = COORD_W'(line_total(t) - 16'd1);
    v_last   = COORD_W'(frame_total(t) - 16'd1);
    hs_first = COORD_W'(16'(t.h_vis) + 16'(t.hfp));
    hs_last  = COORD_W'(16'(t.h_vis) + 16'(t.hfp) + 16'(t.hsw) - 16'd1);
    vs_first = COORD_W'(16'(t.v_vis) + 16'(t.vfp));
    vs_last  = COORD_W'(16'(t.v_vis) + 16'(t.vfp) + 16'(t.vsw) - 16'd1);
    pol      = t.pol;
  end
endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode raster timing generator: pixel/line counters, frame counter and
// frame-synchronous mode switching, with zero-latency sync/blank decode.
module video_timing_gen
  import starsoc_params::*;
#(
  parameter int          COORD_W    = 12,
  parameter int          FCNT_W     = 16,
  parameter int          RESET_MODE = 0,
  parameter mode_table_t TIMING     = MODE_TABLE
) (
  input  logic               pixel_clk,
  input  logic               reset,
  video_timing_gen_if.master vtg
);
  logic [COORD_W-1:0] pixel_x_reg, pixel_y_reg;
  logic [FCNT_W-1:0]  frame_count_reg;
  logic [1:0]         mode_active_reg;

  logic [COORD_W-1:0] h_last, v_last, h_vis, v_vis;
  logic [COORD_W-1:0] hs_first, hs_last, vs_first, vs_last;
  logic               pol, line_end, frame_end, hs_in, vs_in, hblank, vblank, line_start;

  vtg_mode_decode #(.COORD_W(COORD_W), .TIMING(TIMING)) u_decode (
    .mode     (mode_active_reg),
    .h_last   (h_last),
    .v_last   (v_last),
    .h_vis    (h_vis),
    .v_vis    (v_vis),
    .hs_first (hs_first),
    .hs_last  (hs_last),
    .vs_first (vs_first),
    .vs_last  (vs_last),
    .pol      (pol)
  );

  // >= rather than == keeps the counters bounded even from an out-of-range state.
  assign line_end  = pixel_x_reg >= h_last;
  assign frame_end = line_end && (pixel_y_reg >= v_last);

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      frame_count_reg <= '0;
      mode_active_reg <= 2'(RESET_MODE);
    end else if (vtg.vtg_ce) begin
      if (line_end) begin
        pixel_x_reg <= '0;
        if (frame_end) begin
          pixel_y_reg     <= '0;
          frame_count_reg <= frame_count_reg + FCNT_W'(1);
          if (vtg.mode_sel != 2'd3) begin
            mode_active_reg <= vtg.mode_sel;
          end
        end else begin
          pixel_y_reg <= pixel_y_reg + COORD_W'(1);
        end
      end else begin
        pixel_x_reg <= pixel_x_reg + COORD_W'(1);
      end
    end
  end

  assign hs_in      = (pixel_x_reg >= hs_first) && (pixel_x_reg <= hs_last);
  assign vs_in      = (pixel_y_reg >= vs_first) && (pixel_y_reg <= vs_last);
  assign hblank     = pixel_x_reg >= h_vis;
  assign vblank     = pixel_y_reg >= v_vis;
  assign line_start = vtg.vtg_ce && (pixel_x_reg == '0);

  assign vtg.pixel_x     = pixel_x_reg;
  assign vtg.pixel_y     = pixel_y_reg;
  assign vtg.hsync       = hs_in ~^ pol;
  assign vtg.vsync       = vs_in ~^ pol;
  assign vtg.hblank      = hblank;
  assign vtg.vblank      = vblank;
  assign vtg.video_on    = !hblank && !vblank;
  assign vtg.line_start  = line_start;
  assign vtg.frame_start = line_start && (pixel_y_reg == '0);
  assign vtg.frame_count = frame_count_reg;
  assign vtg.mode_active = mode_active_reg;
  assign vtg.mode_err    = !reset && vtg.vtg_ce && frame_end && (vtg.mode_sel == 2'd3);
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: dut_a runs the real 640x480 table over its first lines, dut_b a
// shrunken three-mode table so frame wraps, mode switches and counter wrap stay short.
module tb_video_timing_gen;
  import starsoc_params::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Small table: mode0 8/2/3/2 x 4/1/2/1 high, mode1 6/1/2/1 x 3/1/1/1 low, mode2 10/2/2/2 x 5/1/1/1 high
  localparam timing_t S0 = '{12'd8, 12'd2, 12'd3, 12'd2, 12'd4, 12'd1, 12'd2, 12'd1, 1'b1};
  localparam timing_t S1 = '{12'd6, 12'd1, 12'd2, 12'd1, 12'd3, 12'd1, 12'd1, 12'd1, 1'b0};
  localparam timing_t S2 = '{12'd10, 12'd2, 12'd2, 12'd2, 12'd5, 12'd1, 12'd1, 12'd1, 1'b1};
  localparam mode_table_t SMALL_TAB = {S2, S1, S0};

  localparam int HT  [3] = '{15, 10, 16};
  localparam int VT  [3] = '{8, 6, 8};
  localparam int HV  [3] = '{8, 6, 10};
  localparam int VV  [3] = '{4, 3, 5};
  localparam int HS0 [3] = '{10, 7, 12};
  localparam int HS1 [3] = '{12, 8, 13};
  localparam int VS0 [3] = '{5, 4, 6};
  localparam int VS1 [3] = '{6, 4, 6};
  localparam int PL  [3] = '{1, 0, 1};

  video_timing_gen_if #(.COORD_W(12), .FCNT_W(16)) ia ();
  video_timing_gen_if #(.COORD_W(12), .FCNT_W(2))  ib ();

  video_timing_gen #(.COORD_W(12), .FCNT_W(16), .RESET_MODE(0)) dut_a (
    .pixel_clk (clk),
    .reset     (rst_a),
    .vtg       (ia)
  );

  video_timing_gen #(.COORD_W(12), .FCNT_W(2), .RESET_MODE(0), .TIMING(SMALL_TAB)) dut_b (
    .pixel_clk (clk),
    .reset     (rst_b),
    .vtg       (ib)
  );

  int ax = 0, ay = 0;
  int bx = 0, by = 0, bfc = 0, bmode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_a(input logic ce, input logic rs);
    logic ls;
    rst_a = rs;
    ia.vtg_ce = ce;
    @(negedge clk);
    ls = ce && (ax == 0);
    check("a_x", ia.pixel_x, ax);
    check("a_y", ia.pixel_y, ay);
    check("a_hsync", ia.hsync, (ax >= 656) && (ax <= 751));
    check("a_hblank", ia.hblank, ax >= 640);
    check("a_vsync", ia.vsync, 0);
    check("a_vblank", ia.vblank, 0);
    check("a_video_on", ia.video_on, ax < 640);
    check("a_line_start", ia.line_start, ls);
    check("a_frame_start", ia.frame_start, ls && (ay == 0));
    check("a_fcount", ia.frame_count, 0);
    check("a_mode", ia.mode_active, 0);
    check("a_mode_err", ia.mode_err, 0);
    @(posedge clk);
    if (rs) begin
      ax = 0; ay = 0;
    end else if (ce) begin
      if (ax == 799) begin ax = 0; ay++; end
      else ax++;
    end
    #1;
  endtask

  task automatic tick_b(input logic ce, input logic [1:0] ms, input logic rs);
    logic hs_in, vs_in, ls, fe;
    rst_b = rs;
    ib.vtg_ce = ce;
    ib.mode_sel = ms;
    @(negedge clk);
    hs_in = (bx >= HS0[bmode]) && (bx <= HS1[bmode]);
    vs_in = (by >= VS0[bmode]) && (by <= VS1[bmode]);
    ls = ce && (bx == 0);
    fe = (bx == HT[bmode] - 1) && (by == VT[bmode] - 1);
    check("b_x", ib.pixel_x, bx);
    check("b_y", ib.pixel_y, by);
    check("b_hsync", ib.hsync, (PL[bmode] == 1) ? hs_in : !hs_in);
    check("b_vsync", ib.vsync, (PL[bmode] == 1) ? vs_in : !vs_in);
    check("b_hblank", ib.hblank, bx >= HV[bmode]);
    check("b_vblank", ib.vblank, by >= VV[bmode]);
    check("b_video_on", ib.video_on, (bx < HV[bmode]) && (by < VV[bmode]));
    check("b_line_start", ib.line_start, ls);
    check("b_frame_start", ib.frame_start, ls && (by == 0));
    check("b_fcount", ib.frame_count, bfc);
    check("b_mode", ib.mode_active, bmode);
    check("b_mode_err", ib.mode_err, !rs && ce && fe && (ms == 2'd3));
    @(posedge clk);
    if (rs) begin
      bx = 0; by = 0; bfc = 0; bmode = 0;
    end else if (ce) begin
      if (bx == HT[bmode] - 1) begin
        bx = 0;
        if (by == VT[bmode] - 1) begin
          by = 0;
          bfc = (bfc + 1) % 4;
          if (ms != 2'd3) bmode = ms;
        end else by++;
      end else bx++;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.vtg_ce = 1'b0; ia.mode_sel = 2'd0;
    ib.vtg_ce = 1'b0; ib.mode_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;

    // dut_a: reset decode, two full lines, ce toggling across a line start, mid-line reset
    repeat (2) tick_a(1'b0, 1'b1);
    ia.mode_sel = 2'd2;
    repeat (2395) tick_a(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick_a((i % 2) == 0, 1'b0);
    repeat (295) tick_a(1'b1, 1'b0);
    check("a_pre_reset_x", ia.pixel_x, 300);
    tick_a(1'b1, 1'b1);
    check("a_post_reset_x", ia.pixel_x, 0);
    check("a_post_reset_y", ia.pixel_y, 0);
    repeat (3) tick_a(1'b1, 1'b0);

    // dut_b: frame wraps, mode switch, invalid mode, counter wrap, mid-frame reset
    repeat (2) tick_b(1'b0, 2'd0, 1'b1);
    repeat (120) tick_b(1'b1, 2'd0, 1'b0);
    check("b_fc_frame1", ib.frame_count, 1);
    repeat (30) tick_b(1'b1, 2'd0, 1'b0);
    repeat (89) tick_b(1'b1, 2'd2, 1'b0);
    check("b_before_wrap_x", ib.pixel_x, 14);
    check("b_before_wrap_mode", ib.mode_active, 0);
    tick_b(1'b1, 2'd2, 1'b0);
    check("b_switch_mode", ib.mode_active, 2);
    check("b_fc_frame2", ib.frame_count, 2);
    repeat (127) tick_b(1'b1, 2'd2, 1'b0);
    tick_b(1'b1, 2'd3, 1'b0);
    check("b_invalid_mode_kept", ib.mode_active, 2);
    check("b_fc_frame3", ib.frame_count, 3);
    for (int i = 0; i < 40; i++) tick_b((i % 2) == 0, 2'd1, 1'b0);
    repeat (108) tick_b(1'b1, 2'd1, 1'b0);
    check("b_fc_wrap0", ib.frame_count, 0);
    check("b_mode1", ib.mode_active, 1);
    repeat (59) tick_b(1'b1, 2'd1, 1'b0);
    tick_b(1'b0, 2'd3, 1'b0);
    tick_b(1'b1, 2'd1, 1'b0);
    check("b_fc_frame5", ib.frame_count, 1);
    repeat (20) tick_b(1'b1, 2'd0, 1'b0);
    tick_b(1'b1, 2'd0, 1'b1);
    check("b_reset_y", ib.pixel_y, 0);
    check("b_reset_fc", ib.frame_count, 0);
    check("b_reset_mode", ib.mode_active, 0);
    repeat (5) tick_b(1'b1, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter COORD_W, default 12, width of pixel_x/pixel_y.
REQ-002 Parameter FCNT_W, default 16, width of frame_count.
REQ-003 Parameter RESET_MODE, default 0, mode index loaded on reset.
REQ-004 pixel_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vtg_ce  input  1  pixel-advance enable; counters hold when 0.
REQ-007 mode_sel  input  2  requested video mode (0..2 valid, 3 invalid).
REQ-008 pixel_x, pixel_y  output  COORD_W each  current pixel coordinate.
REQ-009 hsync, vsync  output  1 each  sync pulses, asserted level set by mode polarity.
REQ-010 hblank, vblank, video_on  output  1 each  blanking and active-area flags.
REQ-011 line_start, frame_start  output  1 each  single-cycle markers.
REQ-012 frame_count  output  FCNT_W  completed-frame counter.
REQ-013 mode_active  output  2  mode currently being generated.
REQ-014 mode_err  output  1  single-cycle flag: invalid mode_sel sampled at frame wrap.

Function
REQ-015 Mode table (h_vis/hfp/hsw/hbp, v_vis/vfp/vsw/vbp, pol): mode 0 = 640/16/96/48, 480/10/2/33, active-high; mode 1 = 800/40/128/88, 600/1/4/23, active-high; mode 2 = 1280/110/40/220, 720/5/5/20, active-high.
REQ-016 h_total = sum of horizontal fields (800/1056/1650); v_total likewise (525/628/750).
REQ-017 When vtg_ce=1, pixel_x increments; at h_total-1 it wraps to 0 and pixel_y increments; pixel_y wraps to 0 after v_total-1.
REQ-018 When vtg_ce=0, all counters, frame_count, and mode_active hold; line_start, frame_start, mode_err are 0.
REQ-019 hsync asserted iff h_vis+hfp <= pixel_x <= h_vis+hfp+hsw-1 (mode 0: 656..751).
REQ-020 vsync asserted iff v_vis+vfp <= pixel_y <= v_vis+vfp+vsw-1 (mode 0: 490..491).
REQ-021 hblank = (pixel_x >= h_vis); vblank = (pixel_y >= v_vis); video_on = !hblank && !vblank.
REQ-022 hsync/vsync/hblank/vblank/video_on are valid in the same cycle as the pixel_x/pixel_y they describe (zero latency).
REQ-023 line_start = vtg_ce && pixel_x==0; frame_start = line_start && pixel_y==0.
REQ-024 Frame wrap event = vtg_ce && pixel_x==h_total-1 && pixel_y==v_total-1.
REQ-025 On frame wrap, frame_count increments modulo 2^FCNT_W (all-ones wraps to 0).
REQ-026 mode_sel is sampled only on frame wrap; a valid value loads mode_active for the next frame; mid-frame changes have no effect.
REQ-027 If mode_sel==3 at frame wrap, mode_active is unchanged and mode_err pulses for that cycle.
REQ-028 pixel_x never exceeds h_total-1 and pixel_y never exceeds v_total-1 of mode_active.

Reset
REQ-029 On reset: pixel_x=0, pixel_y=0, frame_count=0, mode_active=RESET_MODE, mode_err=0.
REQ-030 Reset dominates vtg_ce; reset mid-frame returns to (0,0) on the next edge, with no frame_count increment.
REQ-031 During reset, outputs decode (0,0): video_on=1, hblank=vblank=hsync=vsync=0.

Structure
REQ-032 Shared package starsoc_params holds a timing_t struct (h_vis, hfp, hsw, hbp, v_vis, vfp, vsw, vbp, pol) and the constant mode-table array indexed by mode.
REQ-033 The existing h_max/v_max/h_visible/v_visible constants remain in starsoc_params and equal mode 0 values.
REQ-034 One sub-module, vtg_mode_decode, maps mode_active to h_total, v_total and the sync/blank boundary constants combinationally.

Verification
REQ-035 Reset, mode 0, vtg_ce=1 for 420000 cycles -> 640x480 frame period exactly 420000 cycles; hsync high only at x 656..751; vsync high only at y 490..491; frame_count=1 after the first wrap.
REQ-036 vtg_ce toggled 1/0 every cycle -> coordinates advance only on enabled cycles; line_start and frame_start are never high while vtg_ce=0.
REQ-037 mode_sel 0->2 at y=100 -> mode_active stays 0 until the wrap at (799,524), then becomes 2; next frame spans 1650x750 with hsync at x 1390..1429.
REQ-038 mode_sel=3 at the frame wrap -> mode_err is a one-cycle pulse and mode_active is unchanged.
REQ-039 Reset asserted at (300,200) -> next cycle (0,0), frame_count unchanged, mode_active=RESET_MODE.
REQ-040 frame_count preloaded near wrap via FCNT_W=2 and 4 frames run -> sequence 1,2,3,0.
